sseg_scroll_controller: RTL and testbench
=========================================

# sseg_scroll_controller

Message-scrolling controller that sequences the four-digit seven-segment time-multiplexer. It holds a 16-entry buffer of segment patterns and drives the four per-digit pattern inputs of the multiplexer with a sliding four-character window that advances at a programmable scroll rate. It sits between the user/system logic that writes message characters and the 4-digit multiplexed display driver.

## Interface
Parameters:
- TICK_MAX, 10_000_000: clock cycles per scroll step (0.1 s at 100 MHz); minimum 2.
- DEPTH, 16: message buffer entries (fixed at 16; address width 4).

Ports:
- clk  in  1  system clock
- reset  in  1  reset; one clock; reset is synchronous and active-high
- wr_en  in  1  write wr_data into buffer entry wr_addr this cycle
- wr_addr  in  4  buffer write address
- wr_data  in  8  segment pattern, active low ({dp,g..a}); 8'hFF = blank
- msg_len  in  5  valid message length, sampled on start
- start  in  1  begin or restart scrolling (level sampled each clk)
- stop  in  1  stop scrolling and blank the display
- dir  in  1  0 = scroll left (offset increments), 1 = scroll right (offset decrements); sampled at each step
- dig3  out  8  leftmost digit pattern (to multiplexer in3)
- dig2  out  8  to multiplexer in2
- dig1  out  8  to multiplexer in1
- dig0  out  8  rightmost digit pattern (to multiplexer in0)
- running  out  1  high while in RUN
- wrap  out  1  one-cycle pulse when the offset wraps

## Operation
- State machine: IDLE, RUN.
- IDLE: tick counter held at 0; digits driven 8'hFF. start (with stop low) -> latch len = clamp(msg_len, 1, 16), offset = 0, tick = 0, go RUN.
- RUN: tick counts 0..TICK_MAX-1. At tick == TICK_MAX-1: tick -> 0 and offset steps.
  - dir=0: offset = (offset == len-1) ? 0 : offset+1; wrap when the new offset is 0.
  - dir=1: offset = (offset == 0) ? len-1 : offset-1; wrap when the new offset is len-1.
- Window: idx0 = offset; idx(k+1) = (idx(k) == len-1) ? 0 : idx(k)+1. dig3 = buf[idx0], dig2 = buf[idx1], dig1 = buf[idx2], dig0 = buf[idx3]. Messages with len < 4 repeat across the window. Plain modulo-by-subtraction is not used.
- Priority within a cycle: reset > stop > start > tick step. Assert stop and start together -> IDLE. start in RUN restarts: relatch len, offset 0, tick 0, no wrap pulse.
- Buffer writes are accepted in any state. On a write/read collision the new data appears one cycle after the write.
- msg_len changes have no effect until the next start.

## Timing
- Reset (synchronous): state IDLE, tick 0, offset 0, len 1, all buffer entries 8'hFF, dig0..dig3 8'hFF, running 0, wrap 0.
- Digit outputs are registered. The value at edge n+1 reflects the state, offset, and buffer at edge n.
- start sampled at edge n: running = 1 after edge n; the offset-0 frame appears after edge n+1.
- Scroll step: TICK_MAX cycles after entering RUN, then every TICK_MAX cycles. The new offset is registered at the step edge; digits update one edge later.
- wrap is registered. It is high for exactly the one cycle in which the offset register holds its wrapped value.
- stop sampled at edge n: running = 0 after edge n; digits show 8'hFF after edge n+1.
- Buffer write at edge n: the entry updates at edge n; a displayed digit changes after edge n+1.

## Test plan
All scenarios use TICK_MAX=4.
- Reset: assert reset for 2 cycles mid-RUN -> dig3..dig0 = FF,FF,FF,FF; running=0; wrap=0. A following start with len 4 and no writes shows FF x4 (buffer cleared).
- Left scroll: write buf0..5 = C0,F9,A4,B0,99,92, msg_len=6, dir=0, start.
  - Frame C0,F9,A4,B0 two cycles after start.
  - After 4 cycles: F9,A4,B0,99.
  - After the 6th step: wrap pulses for 1 cycle and the frame returns to C0,F9,A4,B0.
- Short message: buf0=C0, buf1=F9, msg_len=2, start -> frame C0,F9,C0,F9. msg_len=0, start -> clamps to 1; frame C0,C0,C0,C0; wrap pulses every 4 cycles.
- Right scroll: len 6 buffer as above, dir=1, start. The first step moves offset 0 -> 5: frame 92,C0,F9,A4, with wrap pulsing in the same cycle the offset is 5.
- Control priority in RUN:
  - stop and start asserted together -> IDLE; running=0; digits FF next cycle.
  - start alone at offset 3 -> offset 0; tick restarts; no wrap pulse.
- Live write: in RUN with offset 0, write buf0 = 88 -> dig3 = 88 two edges after the write edge; other digits unchanged.

Source files
------------

// File: rtl/sseg_scroll_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scroll_controller_if
// Description : Write/control/display bundle for the seven-segment scroll
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface sseg_scroll_controller_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] msg_len;
  logic       start;
  logic       stop;
  logic       dir;
  logic [7:0] dig3;
  logic [7:0] dig2;
  logic [7:0] dig1;
  logic [7:0] dig0;
  logic       running;
  logic       wrap;

  modport master (
    output wr_en, wr_addr, wr_data, msg_len, start, stop, dir,
    input  dig3, dig2, dig1, dig0, running, wrap
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, msg_len, start, stop, dir,
    output dig3, dig2, dig1, dig0, running, wrap
  );
endinterface
`default_nettype wire

// File: rtl/sseg_scroll_controller.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scroll_controller
// Description : 16-entry segment-pattern buffer shown as a scrolling
//               four-character window on a multiplexed display.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scroll_controller #(
  parameter int TICK_MAX = 10_000_000,
  parameter int DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  sseg_scroll_controller_if.slave  bus
);

  localparam int              TW        = $clog2(TICK_MAX);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_MAX - 1);
  localparam logic [0:0]      S_IDLE    = 1'b0;
  localparam logic [0:0]      S_RUN     = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    offset_q, offset_d;
  logic [3:0]    len_m1_q, len_m1_d;
  logic          wrap_q, wrap_d;
  logic [7:0]    buf_q [DEPTH];
  logic [7:0]    buf_d [DEPTH];
  logic [7:0]    dig_q [4];
  logic [7:0]    dig_d [4];
  logic [3:0]    idx   [4];
  logic          running;
  logic          step;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (bus.stop)       state_d = S_IDLE;
    else if (bus.start) state_d = S_RUN;
  end

  // ---------------- FSM outputs ----------------
  always_comb begin
    running = (state_q == S_RUN);
  end

  assign step = running && (tick_q == TICK_LAST) && !bus.stop && !bus.start;

  // Window indices walk forward from the offset, wrapping at the message end
  assign idx[0] = offset_q;
  for (genvar k = 1; k < 4; k++) begin : g_win
    assign idx[k] = (idx[k-1] == len_m1_q) ? 4'd0 : idx[k-1] + 4'd1;
  end

  always_comb begin
    tick_d   = tick_q;
    offset_d = offset_q;
    len_m1_d = len_m1_q;
    wrap_d   = 1'b0;
    buf_d    = buf_q;
    if (bus.wr_en) buf_d[bus.wr_addr] = bus.wr_data;

    if (bus.stop) begin
      tick_d = '0;
    end else if (bus.start) begin
      tick_d   = '0;
      offset_d = 4'd0;
      if (bus.msg_len == 5'd0)       len_m1_d = 4'd0;
      else if (bus.msg_len >= 5'd16) len_m1_d = 4'd15;
      else                           len_m1_d = bus.msg_len[3:0] - 4'd1;
    end else if (!running) begin
      tick_d = '0;
    end else if (step) begin
      tick_d = '0;
      if (!bus.dir) begin
        offset_d = (offset_q == len_m1_q) ? 4'd0 : offset_q + 4'd1;
        wrap_d   = (offset_q == len_m1_q);
      end else begin
        offset_d = (offset_q == 4'd0) ? len_m1_q : offset_q - 4'd1;
        wrap_d   = (offset_q == 4'd0);
      end
    end else begin
      tick_d = tick_q + 1'b1;
    end

    for (int k = 0; k < 4; k++) begin
      dig_d[k] = running ? buf_q[idx[k]] : 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q   <= '0;
      offset_q <= 4'd0;
      len_m1_q <= 4'd0;
      wrap_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= 8'hFF;
      for (int k = 0; k < 4; k++)     dig_q[k] <= 8'hFF;
    end else begin
      tick_q   <= tick_d;
      offset_q <= offset_d;
      len_m1_q <= len_m1_d;
      wrap_q   <= wrap_d;
      buf_q    <= buf_d;
      dig_q    <= dig_d;
    end
  end

  assign bus.dig3    = dig_q[0];
  assign bus.dig2    = dig_q[1];
  assign bus.dig1    = dig_q[2];
  assign bus.dig0    = dig_q[3];
  assign bus.running = running;
  assign bus.wrap    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scroll_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_scroll_controller
// Description : Scoreboard bench for the scroll controller (TICK_MAX = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scroll_controller;

  localparam int TM = 4;

  typedef struct packed {
    logic [31:0] frame;
    logic        running;
    logic        wrap;
  } obs_t;

  logic clk;
  logic reset;
  sseg_scroll_controller_if bus ();

  sseg_scroll_controller #(.TICK_MAX(TM), .DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // reference model: message as an array, window by modulo arithmetic
  bit         m_run;
  int         m_len, m_off, m_tick;
  bit         m_wrap;
  logic [7:0] m_buf [16];

  task automatic model_edge();
    obs_t o;
    o.frame = 32'hFFFF_FFFF;
    if (m_run)
      for (int k = 0; k < 4; k++) o.frame[31-8*k -: 8] = m_buf[(m_off + k) % m_len];
    if (reset) begin
      m_run = 0; m_len = 1; m_off = 0; m_tick = 0; m_wrap = 0;
      for (int i = 0; i < 16; i++) m_buf[i] = 8'hFF;
      o.frame = 32'hFFFF_FFFF;
    end else begin
      if (bus.wr_en) m_buf[bus.wr_addr] = bus.wr_data;
      m_wrap = 0;
      if (bus.stop) begin
        m_run = 0; m_tick = 0;
      end else if (bus.start) begin
        m_run  = 1; m_off = 0; m_tick = 0;
        m_len  = (bus.msg_len == 0) ? 1 : (bus.msg_len > 16) ? 16 : int'(bus.msg_len);
      end else if (m_run) begin
        if (m_tick == TM - 1) begin
          m_tick = 0;
          if (!bus.dir) begin
            m_off  = (m_off + 1) % m_len;
            m_wrap = (m_off == 0);
          end else begin
            m_off  = (m_off + m_len - 1) % m_len;
            m_wrap = (m_off == m_len - 1);
          end
        end else begin
          m_tick++;
        end
      end
    end
    o.running = m_run;
    o.wrap    = m_wrap;
    exp_q.push_back(o);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] len, input logic d);
    bus.msg_len = len; bus.dir = d; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic load_six();
    logic [7:0] pat [6];
    pat = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};
    for (int i = 0; i < 6; i++) write(4'(i), pat[i]);
  endtask

  // monitor: the display is presented every cycle; compare away from the edge
  always @(negedge clk) begin
    obs_t e;
    logic [31:0] act;
    cyc++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
      checks++;
      if (act !== e.frame) begin
        errors++;
        $display("FAIL digits cyc %0d got %h exp %h", cyc, act, e.frame);
      end
      checks++;
      if (bus.running !== e.running) begin
        errors++;
        $display("FAIL running cyc %0d got %b exp %b", cyc, bus.running, e.running);
      end
      checks++;
      if (bus.wrap !== e.wrap) begin
        errors++;
        $display("FAIL wrap cyc %0d got %b exp %b", cyc, bus.wrap, e.wrap);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.msg_len = 0; bus.start = 0; bus.stop = 0; bus.dir = 0;
    #1;
    steps(2);
    reset = 1'b0;
    steps(2);

    // left scroll, len 6, through a full wrap
    load_six();
    do_start(5'd6, 1'b0);
    steps(30);

    // reset mid-run, then an empty buffer shows blanks
    reset = 1'b1; steps(2); reset = 1'b0;
    do_start(5'd4, 1'b0);
    steps(8);

    // short messages, including clamp of 0 to 1
    write(4'd0, 8'hC0); write(4'd1, 8'hF9);
    do_start(5'd2, 1'b0);
    steps(10);
    do_start(5'd0, 1'b0);
    steps(14);

    // right scroll
    load_six();
    do_start(5'd6, 1'b1);
    steps(30);

    // stop together with start
    bus.stop = 1'b1; bus.start = 1'b1; step();
    bus.stop = 1'b0; bus.start = 1'b0; steps(3);

    // restart at offset 3
    do_start(5'd6, 1'b0);
    steps(13);
    do_start(5'd6, 1'b0);
    steps(6);

    // live write while showing offset 0
    do_start(5'd6, 1'b0);
    write(4'd0, 8'h88);
    steps(4);

    // oversize length clamps to 16
    do_start(5'd20, 1'b0);
    steps(70);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      bus.wr_en   = ($urandom_range(0, 2) == 0);
      bus.wr_addr = 4'($urandom_range(0, 15));
      bus.wr_data = 8'($urandom);
      bus.start   = ($urandom_range(0, 39) == 0);
      bus.stop    = ($urandom_range(0, 59) == 0);
      bus.msg_len = 5'($urandom_range(0, 20));
      if ($urandom_range(0, 15) == 0) bus.dir = ~bus.dir;
      reset       = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 0; bus.wr_en = 0; bus.start = 0; bus.stop = 0;
    steps(2);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
